ram_port_scheduler: RTL



---
 rtl/ram_port_scheduler.sv | 139 +++++++++++++
 1 files changed

// File: rtl/ram_port_scheduler.sv
// Init sweeper plus write pass-through and two-way round-robin read arbiter
// in front of a simple-dual-port RAM with one-cycle read latency.
module ram_port_scheduler #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  output logic                  init_done,

  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic [MASK_WIDTH-1:0] w_mask,

  input  logic                  r0_valid,
  output logic                  r0_ready,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic                  r1_valid,
  output logic                  r1_ready,
  input  logic [ADDR_WIDTH-1:0] r1_addr,

  output logic                  rsp_valid,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_data,

  output logic                  ram_wr_en,
  output logic [MASK_WIDTH-1:0] ram_wr_mask,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_INIT  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_prio;
  logic                  r_init_done;
  logic                  r_rsp_valid;
  logic                  r_rsp_id;

  logic w_run;
  logic w_init;
  logic w_elig0;
  logic w_elig1;
  logic w_gnt0;
  logic w_gnt1;

  assign w_run  = (r_state == ST_RUN);
  assign w_init = (r_state == ST_INIT);

  // A pending write to the same address always beats the read.
  assign w_elig0 = w_run && r0_valid && !(w_valid && (r0_addr == w_addr));
  assign w_elig1 = w_run && r1_valid && !(w_valid && (r1_addr == w_addr));
  assign w_gnt0  = w_elig0 && (!w_elig1 || !r_prio);
  assign w_gnt1  = w_elig1 && (!w_elig0 ||  r_prio);

  assign init_done = r_init_done;
  assign w_ready   = w_run;
  assign r0_ready  = w_gnt0;
  assign r1_ready  = w_gnt1;

  assign ram_wr_en   = w_init || (w_run && w_valid);
  assign ram_wr_addr = w_init ? r_cnt : w_addr;
  assign ram_wr_data = w_init ? INIT_VALUE : w_data;
  assign ram_wr_mask = w_init ? {MASK_WIDTH{1'b1}} : w_mask;

  assign ram_rd_en   = w_gnt0 || w_gnt1;
  assign ram_rd_addr = w_gnt1 ? r1_addr : r0_addr;

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = ram_rd_data;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_START;
      r_cnt       <= '0;
      r_prio      <= 1'b0;
      r_init_done <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
    end else begin
      // Responses from grants in this cycle survive a flush.
      r_rsp_valid <= w_gnt0 || w_gnt1;
      if (w_gnt0 || w_gnt1) begin
        r_rsp_id <= w_gnt1;
      end

      if (w_gnt0) begin
        r_prio <= 1'b1;
      end else if (w_gnt1) begin
        r_prio <= 1'b0;
      end

      case (r_state)
        ST_START: begin
          r_state <= ST_INIT;
          r_cnt   <= '0;
        end
        ST_INIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_ADDR) begin
            r_state     <= ST_RUN;
            r_init_done <= 1'b1;
          end
        end
        ST_RUN: begin
          r_state <= ST_RUN;
        end
        default: begin
          r_state     <= ST_START;
          r_init_done <= 1'b0;
        end
      endcase

      if (flush) begin
        r_state     <= ST_INIT;
        r_cnt       <= '0;
        r_prio      <= 1'b0;
        r_init_done <= 1'b0;
      end
    end
  end

endmodule
